// File: rtl/snk68_clk_pkg.sv
// Shared types and constants for the SNK68 clock-enable generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state encoding and the 72 MHz divider defaults.
package snk68_clk_pkg;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_STAB = 2'd1,
    ST_RUN  = 2'd2
  } clk_state_t;

  // clk_sys = 72 MHz: 9 MHz CPU, 4 MHz sound, 6 MHz pixel
  localparam int CPU_DIV_72M = 8;
  localparam int SND_DIV_72M = 18;
  localparam int PIX_DIV_72M = 12;

endpackage

// File: rtl/ce_divider.sv
// Free-running mod-N counter with one registered single-cycle pulse at count PHASE.
// Latency: pulse is high the cycle after the counter sits at PHASE.
// Backpressure: none; mask suppresses the pulse without disturbing the count.
//
// Ports:
//   clk_sys, reset : clock, async active-high reset
//   clr            : force count and pulse to 0 (has priority over run)
//   run            : advance the counter; when low and not clr, count holds, pulse is 0
//   mask           : suppress the pulse for this cycle only
//   cnt            : current count tap (0 .. N-1)
//   pulse          : registered enable pulse
module ce_divider #(
  parameter int N     = 8,
  parameter int PHASE = N - 1,
  parameter int W     = $clog2(N)
) (
  input  logic         clk_sys,
  input  logic         reset,
  input  logic         clr,
  input  logic         run,
  input  logic         mask,
  output logic [W-1:0] cnt,
  output logic         pulse
);

  localparam logic [W-1:0] LAST = W'(N - 1);
  localparam logic [W-1:0] TAP  = W'(PHASE);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      pulse <= 1'b0;
    end else if (clr) begin
      cnt   <= '0;
      pulse <= 1'b0;
    end else if (run) begin
      cnt   <= (cnt == LAST) ? '0 : cnt + 1'b1;
      pulse <= (cnt == TAP) && !mask;
    end else begin
      pulse <= 1'b0;
    end
  end

endmodule

// File: rtl/snk68_clk_ce_gen.sv
// PLL lock qualification, core reset sequencing and all clk_sys clock enables.
// Latency: lock rise -> STAB in 3-4 cycles; STAB -> RUN after LOCK_STABLE_CYCLES, aligned to a CPU period.
// Backpressure: none; pause masks CPU/sound enables in RUN while every counter keeps its phase.
//
// Ports:
//   clk_sys     : 72 MHz system clock        reset      : async active-high reset
//   pll_locked  : PLL locked (asynchronous)   pause      : OSD pause request (synchronous)
//   core_reset  : active-high core reset      running    : high while in RUN
//   ce_cpu_phi1 / ce_cpu_phi2 : 68000 phase enables
//   ce_snd      : Z80/YM3812 enable           ce_pix     : pixel enable (never paused)
module snk68_clk_ce_gen
  import snk68_clk_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES = 4096,
  parameter int CPU_DIV            = CPU_DIV_72M,
  parameter int SND_DIV            = SND_DIV_72M,
  parameter int PIX_DIV            = PIX_DIV_72M
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic pll_locked,
  input  logic pause,
  output logic core_reset,
  output logic running,
  output logic ce_cpu_phi1,
  output logic ce_cpu_phi2,
  output logic ce_snd,
  output logic ce_pix
);

  localparam int SW   = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
  localparam int CW   = $clog2(CPU_DIV);
  localparam int SNDW = $clog2(SND_DIV);
  localparam int PIXW = $clog2(PIX_DIV);

  localparam logic [SW-1:0]   STAB_LAST = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0]   CPU_LAST  = CW'(CPU_DIV - 1);
  localparam logic [CW-1:0]   PHI2_TAP  = CW'(CPU_DIV / 2 - 1);
  localparam logic [SNDW-1:0] SND_LAST  = SNDW'(SND_DIV - 1);
  localparam logic [PIXW-1:0] PIX_LAST  = PIXW'(PIX_DIV - 1);

  logic            lk_meta;
  logic            lk_s;
  clk_state_t      state;
  logic [SW-1:0]   stab_cnt;
  logic            pause_r;
  logic            div_clr;
  logic            div_run;
  logic            cpu_mask;
  logic [CW-1:0]   cpu_cnt;
  logic [SNDW-1:0] snd_cnt;
  logic [PIXW-1:0] pix_cnt;

  // Two-flop synchronizer for the asynchronous PLL lock
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      lk_meta <= 1'b0;
      lk_s    <= 1'b0;
    end else begin
      lk_meta <= pll_locked;
      lk_s    <= lk_meta;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) pause_r <= 1'b0;
    else       pause_r <= pause;
  end

  // Outside WAIT, losing lk_s is exactly the condition that sends the FSM to
  // WAIT on this edge, so clearing on !lk_s makes the first WAIT cycle already
  // show zero counts and zero enables.
  assign div_clr  = (state == ST_WAIT) || !lk_s;
  assign div_run  = !div_clr;
  assign cpu_mask = pause_r && (state == ST_RUN);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= ST_WAIT;
      stab_cnt   <= '0;
      core_reset <= 1'b1;
      running    <= 1'b0;
    end else begin
      unique case (state)
        ST_WAIT: begin
          stab_cnt <= '0;
          if (lk_s) state <= ST_STAB;
        end
        ST_STAB: begin
          if (stab_cnt != STAB_LAST) stab_cnt <= stab_cnt + 1'b1;
          if (!lk_s) begin
            state    <= ST_WAIT;
            stab_cnt <= '0;
          end else if (stab_cnt == STAB_LAST && cpu_cnt == CPU_LAST) begin
            // Release on a CPU period boundary so the first RUN cycle carries phi1
            state      <= ST_RUN;
            core_reset <= 1'b0;
            running    <= 1'b1;
          end
        end
        ST_RUN: begin
          stab_cnt <= '0;
          if (!lk_s) begin
            state      <= ST_WAIT;
            core_reset <= 1'b1;
            running    <= 1'b0;
          end
        end
        default: begin
          state      <= ST_WAIT;
          stab_cnt   <= '0;
          core_reset <= 1'b1;
          running    <= 1'b0;
        end
      endcase
    end
  end

  ce_divider #(.N(CPU_DIV), .PHASE(CPU_DIV - 1)) u_cpu_div (
    .clk_sys (clk_sys),
    .reset   (reset),
    .clr     (div_clr),
    .run     (div_run),
    .mask    (cpu_mask),
    .cnt     (cpu_cnt),
    .pulse   (ce_cpu_phi1)
  );

  // phi2 is the half-period tap of the CPU counter, gated exactly like phi1
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) ce_cpu_phi2 <= 1'b0;
    else       ce_cpu_phi2 <= div_run && !cpu_mask && (cpu_cnt == PHI2_TAP);
  end

  ce_divider #(.N(SND_DIV), .PHASE(SND_DIV - 1)) u_snd_div (
    .clk_sys (clk_sys),
    .reset   (reset),
    .clr     (div_clr),
    .run     (div_run),
    .mask    (cpu_mask),
    .cnt     (snd_cnt),
    .pulse   (ce_snd)
  );

  ce_divider #(.N(PIX_DIV), .PHASE(PIX_DIV - 1)) u_pix_div (
    .clk_sys (clk_sys),
    .reset   (reset),
    .clr     (div_clr),
    .run     (div_run),
    .mask    (1'b0),
    .cnt     (pix_cnt),
    .pulse   (ce_pix)
  );

  // Wrap invariant of the sound and pixel counters
  a_snd_range: assert property (@(posedge clk_sys) disable iff (reset) snd_cnt <= SND_LAST);
  a_pix_range: assert property (@(posedge clk_sys) disable iff (reset) pix_cnt <= PIX_LAST);

endmodule

// File: tb/tb_snk68_clk_ce_gen.sv
module tb_snk68_clk_ce_gen;

  localparam int END_CYC = 490;
  // pause windows: pause driven high in cycle ON, low in cycle OFF
  localparam int P0_ON = 30,  P0_OFF = 35;   // during STAB: no effect
  localparam int P1_ON = 100, P1_OFF = 200;  // in RUN
  localparam int P2_ON = 290, P2_OFF = 320;  // spans the lock loss

  logic clk_sys = 1'b0;
  logic reset, pll_locked, pause;
  logic core_reset, running, ce_cpu_phi1, ce_cpu_phi2, ce_snd, ce_pix;
  logic rst13, run13, phi1_13, phi2_13, snd13, pix13;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  int overlap = 0;

  int q_phi1[$], q_phi2[$], q_snd[$], q_pix[$];
  int q_rst_cyc[$], q_rst_val[$], q_rst13_cyc[$], q_rst13_val[$];
  int n_exp_phi1 = 0, n_exp_phi2 = 0, n_exp_snd = 0, n_exp_pix = 0;
  int n13_phi1 = 0, n13_phi2 = 0, n13_snd = 0, n13_pix = 0;
  logic prev_rst = 1'b1;
  logic prev_rst13 = 1'b1;

  snk68_clk_ce_gen #(.LOCK_STABLE_CYCLES(16)) u_dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .pll_locked  (pll_locked),
    .pause       (pause),
    .core_reset  (core_reset),
    .running     (running),
    .ce_cpu_phi1 (ce_cpu_phi1),
    .ce_cpu_phi2 (ce_cpu_phi2),
    .ce_snd      (ce_snd),
    .ce_pix      (ce_pix)
  );

  // Unaligned stable count: 13 must still release on the CPU boundary, same cycle as 16
  snk68_clk_ce_gen #(.LOCK_STABLE_CYCLES(13)) u_dut13 (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .pll_locked  (pll_locked),
    .pause       (pause),
    .core_reset  (rst13),
    .running     (run13),
    .ce_cpu_phi1 (phi1_13),
    .ce_cpu_phi2 (phi2_13),
    .ce_snd      (snd13),
    .ce_pix      (pix13)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic go(input int n);
    while (cyc < n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  function automatic bit masked(input int c, input int r);
    if (c - 1 < r) return 1'b0;
    return (c >= P0_ON + 2 && c <= P0_OFF + 1) ||
           (c >= P1_ON + 2 && c <= P1_OFF + 1) ||
           (c >= P2_ON + 2 && c <= P2_OFF + 1);
  endfunction

  // Expected enables for one lock segment: STAB entry s, RUN entry r, WAIT entry w
  task automatic push_seg(input int s, input int r, input int w);
    int k;
    for (int c = s + 1; c <= w - 1; c++) begin
      k = c - s;
      if (k % 8 == 0 && !masked(c, r))  begin q_phi1.push_back(c); n_exp_phi1++; end
      if (k % 8 == 4 && !masked(c, r))  begin q_phi2.push_back(c); n_exp_phi2++; end
      if (k % 18 == 0 && !masked(c, r)) begin q_snd.push_back(c);  n_exp_snd++;  end
      if (k % 12 == 0)                  begin q_pix.push_back(c);  n_exp_pix++;  end
    end
  endtask

  task automatic push_rst(input int c, input int v);
    q_rst_cyc.push_back(c);   q_rst_val.push_back(v);
    q_rst13_cyc.push_back(c); q_rst13_val.push_back(v);
  endtask

  task automatic mon_pulse(input string name, input logic v, ref int q[$]);
    int e;
    if (v) begin
      if (q.size() == 0) chk({name, " unexpected pulse"}, cyc, -1);
      else begin
        e = q.pop_front();
        chk(name, cyc, e);
      end
    end
  endtask

  task automatic mon_rst(input string name, input logic r, input logic run, ref logic prev,
                         ref int qc[$], ref int qv[$]);
    int e, v;
    if (r !== prev) begin
      if (qc.size() == 0) chk({name, " unexpected edge"}, cyc, -1);
      else begin
        e = qc.pop_front();
        v = qv.pop_front();
        chk({name, " edge cycle"}, cyc, e);
        chk({name, " edge value"}, int'(r), v);
        chk({name, " running"}, int'(run), 1 - v);
      end
    end
    prev = r;
  endtask

  always @(negedge clk_sys) begin
    if (cyc >= 1 && cyc <= END_CYC) begin
      mon_pulse("ce_cpu_phi1", ce_cpu_phi1, q_phi1);
      mon_pulse("ce_cpu_phi2", ce_cpu_phi2, q_phi2);
      mon_pulse("ce_snd", ce_snd, q_snd);
      mon_pulse("ce_pix", ce_pix, q_pix);
      mon_rst("core_reset", core_reset, running, prev_rst, q_rst_cyc, q_rst_val);
      mon_rst("core_reset13", rst13, run13, prev_rst13, q_rst13_cyc, q_rst13_val);
      if (ce_cpu_phi1 && ce_cpu_phi2) overlap++;
      n13_phi1 += int'(phi1_13);
      n13_phi2 += int'(phi2_13);
      n13_snd  += int'(snd13);
      n13_pix  += int'(pix13);
    end
  end

  initial begin
    reset = 1'b1;
    pll_locked = 1'b0;
    pause = 1'b0;

    go(1);
    chk("reset core_reset", int'(core_reset), 1);
    chk("reset running", int'(running), 0);
    chk("reset phi1", int'(ce_cpu_phi1), 0);
    chk("reset phi2", int'(ce_cpu_phi2), 0);
    chk("reset snd", int'(ce_snd), 0);
    chk("reset pix", int'(ce_pix), 0);

    go(2);
    reset = 1'b0;

    // Lock at 10 -> STAB at 13; glitch at stab_cnt=10 (cycle 23) -> WAIT at 26
    go(10);
    push_seg(13, 26, 26);
    pll_locked = 1'b1;
    go(23);
    pll_locked = 1'b0;

    // Relock at 26 -> STAB at 29, RUN at 45, lock loss at 300 -> WAIT at 303
    go(26);
    push_seg(29, 45, 303);
    push_rst(45, 0);
    push_rst(303, 1);
    pll_locked = 1'b1;
    go(P0_ON);  pause = 1'b1;
    go(P0_OFF); pause = 1'b0;
    go(P1_ON);  pause = 1'b1;
    go(P1_OFF); pause = 1'b0;
    go(P2_ON);  pause = 1'b1;
    go(300);    pll_locked = 1'b0;
    go(P2_OFF); pause = 1'b0;

    // Relock at 330 -> STAB at 333, RUN at 349; async reset in cycle 405
    go(330);
    push_seg(333, 349, 405);
    push_rst(349, 0);
    push_rst(405, 1);
    pll_locked = 1'b1;

    go(405);
    chk("pre-reset phi1", int'(ce_cpu_phi1), 1);
    chk("pre-reset snd", int'(ce_snd), 1);
    chk("pre-reset pix", int'(ce_pix), 1);
    #1 reset = 1'b1;
    #2;
    chk("async core_reset", int'(core_reset), 1);
    chk("async running", int'(running), 0);
    chk("async phi1", int'(ce_cpu_phi1), 0);
    chk("async phi2", int'(ce_cpu_phi2), 0);
    chk("async snd", int'(ce_snd), 0);
    chk("async pix", int'(ce_pix), 0);

    // Release at 407 with lock held -> STAB at 410, RUN at 426
    go(407);
    push_seg(410, 426, END_CYC + 1);
    push_rst(426, 0);
    reset = 1'b0;

    go(END_CYC + 2);
    chk("phi1 missing", q_phi1.size(), 0);
    chk("phi2 missing", q_phi2.size(), 0);
    chk("snd missing", q_snd.size(), 0);
    chk("pix missing", q_pix.size(), 0);
    chk("core_reset edges missing", q_rst_cyc.size(), 0);
    chk("core_reset13 edges missing", q_rst13_cyc.size(), 0);
    chk("phi1/phi2 overlap", overlap, 0);
    chk("dut13 phi1 count", n13_phi1, n_exp_phi1);
    chk("dut13 phi2 count", n13_phi2, n_exp_phi2);
    chk("dut13 snd count", n13_snd, n_exp_snd);
    chk("dut13 pix count", n13_pix, n_exp_pix);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
